pc_redirect_ctrl: RTL

Fetch-side PC sequencer that consumes the branch/jump decision rather than producing it. It holds the program counter and tracks conditional branches from decode to execute. It generates the one-cycle-delayed branch flag used by the redirect decision, loads the target on a taken branch or jump, and drives the IF/ID flush and fetch-valid qualifiers. It sits between the decoder/ALU and the instruction-memory address port.

---
 rtl/pc_redirect_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-side program counter sequencer.
// Holds the fetch PC. Tracks a conditional branch from decode until it resolves
// in execute, and applies jump or taken-branch redirects. After a redirect it
// holds the IF/ID flush for a programmable number of cycles.
module pc_redirect_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            branch_o_delayed,
    output logic            pc_src_o,
    output logic            flush_o,
    output logic            fetch_valid_o,
    output logic [15:0]     taken_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            branchDly_q;
    logic            pcSrc_q;
    logic            flush_q;
    logic [3:0]      flushCnt_q;
    logic [15:0]     takenCnt_q;

    logic [XLEN-1:0] targetAligned;
    logic [XLEN-1:0] pcPlus4;
    logic [15:0]     takenNext;

    // The redirect target is forced to a word boundary.
    // The sequential PC wraps naturally at 2^XLEN.
    // The redirect counter sticks at its maximum instead of rolling over.
    assign targetAligned = target_i & ~XLEN'(3);
    assign pcPlus4       = pc_q + XLEN'(4);
    assign takenNext     = (takenCnt_q == 16'hFFFF) ? takenCnt_q : takenCnt_q + 16'd1;

    // Sequencer FSM: advances the PC, tracks a pending branch, and times the post-redirect flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            branchDly_q <= 1'b0;
            pcSrc_q     <= 1'b0;
            flush_q     <= 1'b0;
            flushCnt_q  <= 4'd0;
            takenCnt_q  <= 16'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_i) begin
                        state_q <= RUN;
                    end else if (jump_i) begin
                        pc_q       <= targetAligned;
                        pcSrc_q    <= 1'b1;
                        flush_q    <= 1'b1;
                        flushCnt_q <= 4'(FLUSH_CYCLES - 1);
                        takenCnt_q <= takenNext;
                        state_q    <= FLUSH;
                    end else if (branch_i) begin
                        branchDly_q <= 1'b1;
                        state_q     <= RESOLVE;
                    end else begin
                        pc_q <= pcPlus4;
                    end
                end
                RESOLVE: begin
                    if (stall_i) begin
                        state_q <= RESOLVE;
                    end else if (zero_i) begin
                        pc_q        <= targetAligned;
                        pcSrc_q     <= 1'b1;
                        flush_q     <= 1'b1;
                        flushCnt_q  <= 4'(FLUSH_CYCLES - 1);
                        takenCnt_q  <= takenNext;
                        branchDly_q <= 1'b0;
                        state_q     <= FLUSH;
                    end else begin
                        pc_q        <= pcPlus4;
                        branchDly_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                FLUSH: begin
                    pcSrc_q <= 1'b0;
                    if (flushCnt_q == 4'd0) begin
                        flush_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        flushCnt_q <= flushCnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc_o             = pc_q;
    assign branch_o_delayed = branchDly_q;
    assign pc_src_o         = pcSrc_q;
    assign flush_o          = flush_q;
    assign taken_cnt_o      = takenCnt_q;
    assign fetch_valid_o    = rst_n && (state_q == RUN);

endmodule
